// File: rtl/truth_table_checker_pkg.sv
// Shared types and sizing helpers for the exhaustive truth-table checker.
// Module parameters default to the values here; widths are derived through the helpers.
package truth_table_checker_pkg;

   localparam int N_IN_DEF   = 3;
   localparam int N_FUNC_DEF = 5;
   localparam int SETTLE_DEF = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   function automatic int nvec(input int n_in);
      return 2 ** n_in;
   endfunction

   // err_count has to be able to hold every vector failing, i.e. 2^n_in
   function automatic int cnt_width(input int n_in);
      return n_in + 1;
   endfunction

   // The settle counter holds SETTLE-1 at most.
   function automatic int wait_width(input int settle);
      return (settle > 1) ? $clog2(settle) : 1;
   endfunction

   localparam int NVEC  = nvec(N_IN_DEF);
   localparam int CNT_W = cnt_width(N_IN_DEF);
   localparam int WAIT_W = wait_width(SETTLE_DEF);

endpackage

// File: rtl/truth_table_checker_if.sv
// Stimulus/response bundle between the checker and the expression pairs it drives.
// master = checker side, slave = the paired modules / observer side.
interface truth_table_checker_if #(
   parameter int N_IN   = 3,
   parameter int N_FUNC = 5
);
   logic              start;
   logic [N_IN-1:0]   vec;
   logic [N_FUNC-1:0] s_orig;
   logic [N_FUNC-1:0] s_simp;
   logic              busy;
   logic              done;
   logic              pass;
   logic [N_IN:0]     err_count;
   logic [N_FUNC-1:0] fail_mask;
   logic [N_IN-1:0]   first_fail_vec;
   logic              first_fail_valid;

   modport master (
      input  start, s_orig, s_simp,
      output vec, busy, done, pass, err_count, fail_mask,
             first_fail_vec, first_fail_valid
   );

   modport slave (
      output start, s_orig, s_simp,
      input  vec, busy, done, pass, err_count, fail_mask,
             first_fail_vec, first_fail_valid
   );
endinterface

// File: rtl/truth_table_checker_vector_sequencer.sv
// Drive-vector counter plus settle down-counter; flags when the current vector
// has been held long enough to sample and when it is the final vector.
module vector_sequencer
   import truth_table_checker_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            advance,
   input  logic            count_en,
   output logic [N_IN-1:0] vec,
   output logic            sample_en,
   output logic            last_vec
);

   localparam int                WAIT_W = wait_width(SETTLE);
   localparam logic [WAIT_W-1:0] RELOAD = WAIT_W'(SETTLE - 1);

   logic [N_IN-1:0]   vec_q;
   logic [WAIT_W-1:0] wait_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_q      <= '0;
         wait_cnt_q <= '0;
      end else if (load) begin
         vec_q      <= '0;
         wait_cnt_q <= RELOAD;
      end else if (advance) begin
         vec_q      <= vec_q + N_IN'(1);
         wait_cnt_q <= RELOAD;
      end else if (count_en && (wait_cnt_q != '0)) begin
         wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
      end
   end

   assign vec       = vec_q;
   assign sample_en = count_en && (wait_cnt_q == '0);
   assign last_vec  = &vec_q;

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive equivalence checker: sweeps every input vector into original/simplified
// expression pairs, compares their outputs and accumulates the failure summary.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no sweep run since reset; waiting for start
// ST_WAIT   | vec held while the paired expressions settle
// ST_SAMPLE | compare s_orig/s_simp for vec, then advance or finish
// ST_DONE   | sweep complete, results held until next start or reset
module truth_table_checker
   import truth_table_checker_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int N_FUNC = N_FUNC_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   truth_table_checker_if.master bus
);

   localparam int CNT_W = cnt_width(N_IN);

   if (SETTLE < 1) begin : g_settle_check
      $error("truth_table_checker: SETTLE must be at least 1");
   end

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  err_q;
   logic [N_FUNC-1:0] mask_q;
   logic [N_IN-1:0]   ffv_q;
   logic              ffvalid_q;

   logic [N_IN-1:0]   vec;
   logic              sample_en;
   logic              last_vec;
   logic              accept;
   logic              advance;
   logic [N_FUNC-1:0] diff;

   assign accept  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign advance = (state_q == ST_SAMPLE) && !last_vec;
   assign diff    = bus.s_orig ^ bus.s_simp;

   vector_sequencer #(
      .N_IN   (N_IN),
      .SETTLE (SETTLE)
   ) u_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .advance   (advance),
      .count_en  (state_q == ST_WAIT),
      .vec       (vec),
      .sample_en (sample_en),
      .last_vec  (last_vec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (sample_en) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            state_d = last_vec ? ST_DONE : ST_WAIT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Inputs are only looked at in SAMPLE; the first failing vec is kept, later ones only counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q     <= '0;
         mask_q    <= '0;
         ffv_q     <= '0;
         ffvalid_q <= 1'b0;
      end else if (accept) begin
         err_q     <= '0;
         mask_q    <= '0;
         ffv_q     <= '0;
         ffvalid_q <= 1'b0;
      end else if (state_q == ST_SAMPLE) begin
         mask_q <= mask_q | diff;
         if (diff != '0) begin
            err_q <= err_q + CNT_W'(1);
            if (!ffvalid_q) begin
               ffv_q     <= vec;
               ffvalid_q <= 1'b1;
            end
         end
      end
   end

   assign bus.vec              = vec;
   assign bus.busy             = (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
   assign bus.done             = (state_q == ST_DONE);
   assign bus.pass             = (state_q == ST_DONE) && (err_q == '0);
   assign bus.err_count        = err_q;
   assign bus.fail_mask        = mask_q;
   assign bus.first_fail_vec   = ffv_q;
   assign bus.first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: five hand-written expression pairs with injectable
// faults; expected sweep summaries are queued at start and checked when done rises.
module tb_truth_table_checker;

   typedef struct {
      logic [3:0] err;
      logic [4:0] mask;
      logic [2:0] ffv;
      logic       ffvalid;
      logic       pass;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic fault0, fault4;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   acc_a, acc_b, tmp;
   logic done_pa = 1'b0, done_pb = 1'b0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   truth_table_checker_if #(.N_IN(3), .N_FUNC(5)) bus_a ();
   truth_table_checker_if #(.N_IN(3), .N_FUNC(5)) bus_b ();

   truth_table_checker #(.N_IN(3), .N_FUNC(5), .SETTLE(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   truth_table_checker #(.N_IN(3), .N_FUNC(5), .SETTLE(3)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   // Pair i in bit i; v = {x,y,z}
   function automatic logic [4:0] f_orig(input logic [2:0] v);
      logic x, y, z;
      {x, y, z} = v;
      return {(x & z) | (x & y & z),
              (x & y) | (~x & z) | (y & z),
              (~x & ~y) | (~x & y),
              (x | y) & (x | ~y),
              (x & ~y) | (x & ~y & z)};
   endfunction

   function automatic logic [4:0] f_simp(input logic [2:0] v, input logic f0, input logic f4);
      logic x, y, z;
      {x, y, z} = v;
      return {f4 ? 1'b1 : (x & z),
              (x & y) | (~x & z),
              ~x,
              x,
              f0 ? (x & y) : (x & ~y)};
   endfunction

   always_comb begin
      bus_a.s_orig = f_orig(bus_a.vec);
      bus_a.s_simp = f_simp(bus_a.vec, fault0, fault4);
      bus_b.s_orig = f_orig(bus_b.vec);
      bus_b.s_simp = f_simp(bus_b.vec, 1'b0, 1'b0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic exp_t mk(input logic [3:0] err, input logic [4:0] mask,
                               input logic [2:0] ffv, input logic ffvalid, input int lat);
      exp_t e;
      e.err = err; e.mask = mask; e.ffv = ffv; e.ffvalid = ffvalid;
      e.pass = (err == 4'd0); e.lat = lat;
      return e;
   endfunction

   // Monitors: compare the queued summary on each rising edge of done.
   always @(negedge clk) begin
      if (bus_a.done && !done_pa) begin
         check("a_expect_queued", qa.size() > 0, 1);
         if (qa.size() > 0) begin
            exp_t e;
            e = qa.pop_front();
            check("a_latency", cyc - acc_a, e.lat);
            check("a_err_count", bus_a.err_count, e.err);
            check("a_fail_mask", bus_a.fail_mask, e.mask);
            check("a_first_fail_vec", bus_a.first_fail_vec, e.ffv);
            check("a_first_fail_valid", bus_a.first_fail_valid, e.ffvalid);
            check("a_pass", bus_a.pass, e.pass);
            check("a_busy_in_done", bus_a.busy, 0);
         end
      end
      done_pa = bus_a.done;
   end

   always @(negedge clk) begin
      if (bus_b.done && !done_pb) begin
         check("b_expect_queued", qb.size() > 0, 1);
         if (qb.size() > 0) begin
            exp_t e;
            e = qb.pop_front();
            check("b_latency", cyc - acc_b, e.lat);
            check("b_err_count", bus_b.err_count, e.err);
            check("b_fail_mask", bus_b.fail_mask, e.mask);
            check("b_first_fail_valid", bus_b.first_fail_valid, e.ffvalid);
            check("b_pass", bus_b.pass, e.pass);
            check("b_final_vec", bus_b.vec, 3'b111);
         end
      end
      done_pb = bus_b.done;
   end

   // Returns #1 after the edge that sampled start; at = cycle count at that edge.
   task automatic pulse_a(output int at);
      @(negedge clk); bus_a.start = 1'b1;
      @(posedge clk); #1; bus_a.start = 1'b0;
      at = cyc;
   endtask

   task automatic pulse_b(output int at);
      @(negedge clk); bus_b.start = 1'b1;
      @(posedge clk); #1; bus_b.start = 1'b0;
      at = cyc;
   endtask

   task automatic wait_done_a(input int budget);
      int n = 0;
      while (!bus_a.done && n < budget) begin @(negedge clk); n++; end
      if (!bus_a.done) check("a_done_timeout", bus_a.done, 1);
      @(negedge clk);
   endtask

   task automatic wait_done_b(input int budget);
      int n = 0;
      while (!bus_b.done && n < budget) begin @(negedge clk); n++; end
      if (!bus_b.done) check("b_done_timeout", bus_b.done, 1);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; fault0 = 1'b0; fault4 = 1'b0;
      bus_a.start = 1'b0; bus_b.start = 1'b0;
      #3;
      check("rst_vec", bus_a.vec, 0);
      check("rst_busy", bus_a.busy, 0);
      check("rst_done", bus_a.done, 0);
      check("rst_pass", bus_a.pass, 0);
      check("rst_err_count", bus_a.err_count, 0);
      check("rst_fail_mask", bus_a.fail_mask, 0);
      check("rst_first_fail_valid", bus_a.first_fail_valid, 0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;

      // equivalent pairs, with a look at vec stepping every 2 cycles
      qa.push_back(mk(4'd0, 5'b00000, 3'b000, 1'b0, 16));
      pulse_a(acc_a);
      check("a_busy_after_start", bus_a.busy, 1);
      repeat (3) @(posedge clk); #1;
      check("a_vec_at_3", bus_a.vec, 1);
      repeat (2) @(posedge clk); #1;
      check("a_vec_at_5", bus_a.vec, 2);
      wait_done_a(40);

      // pair 0 simplified as x&y: fails on every x=1 vector
      fault0 = 1'b1;
      qa.push_back(mk(4'd4, 5'b00001, 3'b100, 1'b1, 16));
      pulse_a(acc_a);
      wait_done_a(40);

      // plus pair 4 stuck at 1: fails on every x=0 vector too
      fault4 = 1'b1;
      qa.push_back(mk(4'd8, 5'b10001, 3'b000, 1'b1, 16));
      pulse_a(acc_a);
      wait_done_a(40);
      check("a_vec_held_in_done", bus_a.vec, 3'b111);

      // start while busy is ignored; start in DONE restarts with cleared outputs
      fault4 = 1'b0;
      qa.push_back(mk(4'd4, 5'b00001, 3'b100, 1'b1, 16));
      pulse_a(acc_a);
      repeat (4) @(posedge clk);
      pulse_a(tmp);
      wait_done_a(40);
      qa.push_back(mk(4'd4, 5'b00001, 3'b100, 1'b1, 16));
      pulse_a(acc_a);
      check("restart_done_cleared", bus_a.done, 0);
      check("restart_err_cleared", bus_a.err_count, 0);
      check("restart_mask_cleared", bus_a.fail_mask, 0);
      check("restart_ffvalid_cleared", bus_a.first_fail_valid, 0);
      check("restart_vec_zero", bus_a.vec, 0);
      wait_done_a(40);

      // reset at cycle 7 of a faulty sweep
      fault4 = 1'b1;
      pulse_a(tmp);
      repeat (7) @(posedge clk);
      check("pre_reset_err_nonzero", bus_a.err_count != 0, 1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_vec", bus_a.vec, 0);
      check("mid_rst_err_count", bus_a.err_count, 0);
      check("mid_rst_fail_mask", bus_a.fail_mask, 0);
      check("mid_rst_done", bus_a.done, 0);
      check("mid_rst_busy", bus_a.busy, 0);
      check("mid_rst_ffvalid", bus_a.first_fail_valid, 0);
      @(negedge clk); rst_n = 1'b1;
      fault0 = 1'b0; fault4 = 1'b0;
      qa.push_back(mk(4'd0, 5'b00000, 3'b000, 1'b0, 16));
      pulse_a(acc_a);
      wait_done_a(40);

      // SETTLE=3 instance: vec steps every 4 cycles, done after 32
      qb.push_back(mk(4'd0, 5'b00000, 3'b000, 1'b0, 32));
      pulse_b(acc_b);
      repeat (3) @(posedge clk); #1;
      check("b_vec_at_3", bus_b.vec, 0);
      @(posedge clk); #1;
      check("b_vec_at_4", bus_b.vec, 1);
      repeat (4) @(posedge clk); #1;
      check("b_vec_at_8", bus_b.vec, 2);
      wait_done_b(80);

      check("a_queue_drained", qa.size(), 0);
      check("b_queue_drained", qb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
